// File: rtl/cla_seq_pkg.sv
// Shared definitions for the CLA operand sequencer: sequencer state encoding
// and default operand/beat widths.
// No ports; imported by cla_operand_sequencer.
package cla_seq_pkg;

   localparam int DEFAULT_N       = 64;
   localparam int DEFAULT_CHUNK_W = 8;

   typedef enum logic [1:0] {
      LOAD_A = 2'd0,
      LOAD_B = 2'd1,
      ADD    = 2'd2,
      HOLD   = 2'd3
   } seq_state_t;

endpackage

// File: rtl/nbit_CLA_full_adder.sv
// Purpose: combinational N-bit carry-lookahead adder, sum = a + b + cin.
// Latency: purely combinational. Backpressure: none (no handshake).
// Ports: a, b (N bits) operands; cin carry-in; sum (N+1 bits), sum[N] = carry-out.
module nbit_CLA_full_adder #(
   parameter int N = 64
) (
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic         cin,
   output logic [N:0]   sum
);

   logic [N-1:0] p0;   // bitwise propagate, also the half-sum
   logic [N-1:0] g;    // group generate over [0..i], carry-in folded into bit 0
   logic [N-1:0] p;    // group propagate over the current prefix span

   assign p0 = a ^ b;

   always_comb begin
      g    = a & b;
      p    = p0;
      g[0] = g[0] | (p0[0] & cin);
      // Kogge-Stone prefix: walk i downwards so g[i-d]/p[i-d] still hold the
      // previous level's values when bit i is combined.
      for (int d = 1; d < N; d = d * 2) begin
         for (int i = N - 1; i >= d; i--) begin
            g[i] = g[i] | (p[i] & g[i-d]);
            p[i] = p[i] & p[i-d];
         end
      end
   end

   always_comb begin
      sum    = '0;
      sum[0] = p0[0] ^ cin;
      for (int i = 1; i < N; i++) begin
         sum[i] = p0[i] ^ g[i-1];
      end
      sum[N] = g[N-1];
   end

endmodule

// File: rtl/cla_operand_sequencer.sv
// Purpose: assembles N-bit A then B from CHUNK_W-bit beats (LSB chunk first),
//   adds them with one CLA and presents the registered N+1-bit sum.
// Latency: result valid on the second edge after the last B beat is accepted;
//   one result per 2*N/CHUNK_W+2 cycles when unstalled.
// Backpressure: in_ready low while adding/holding; result held until out_ready.
// Ports: clk, rst (async, active high); in_valid/in_ready/in_data operand
//   stream; out_valid/out_ready/out_sum result stream (out_sum[N] = carry).
module cla_operand_sequencer
   import cla_seq_pkg::*;
#(
   parameter int N       = DEFAULT_N,
   parameter int CHUNK_W = DEFAULT_CHUNK_W
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [CHUNK_W-1:0] in_data,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [N:0]         out_sum
);

   localparam int NCHUNK = N / CHUNK_W;
   localparam int CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
   localparam logic [CNT_W-1:0] LAST_K = CNT_W'(NCHUNK - 1);

   seq_state_t       state;
   seq_state_t       state_nxt;
   logic [CNT_W-1:0] k;
   logic [N-1:0]     a_reg;
   logic [N-1:0]     b_reg;
   logic [N:0]       adder_sum;
   logic             load_st;
   logic             beat;
   logic             last_beat;

   assign beat      = in_valid && in_ready;
   assign last_beat = (k == LAST_K);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= LOAD_A;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      load_st   = 1'b0;
      unique case (state)
         LOAD_A: begin
            load_st = 1'b1;
            if (beat && last_beat) state_nxt = LOAD_B;
         end
         LOAD_B: begin
            load_st = 1'b1;
            if (beat && last_beat) state_nxt = ADD;
         end
         ADD: begin
            state_nxt = HOLD;
         end
         HOLD: begin
            if (out_valid && out_ready) state_nxt = LOAD_A;
         end
         default: begin
            state_nxt = LOAD_A;
         end
      endcase
   end

   // Gated by rst so the stream closes the moment reset asserts.
   assign in_ready = load_st && !rst;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         k         <= '0;
         a_reg     <= '0;
         b_reg     <= '0;
         out_sum   <= '0;
         out_valid <= 1'b0;
      end else begin
         if (beat) begin
            for (int i = 0; i < NCHUNK; i++) begin
               if (k == CNT_W'(i)) begin
                  if (state == LOAD_A) a_reg[i*CHUNK_W +: CHUNK_W] <= in_data;
                  else                 b_reg[i*CHUNK_W +: CHUNK_W] <= in_data;
               end
            end
            k <= last_beat ? '0 : k + CNT_W'(1);
         end
         if (state == ADD) begin
            out_sum   <= adder_sum;
            out_valid <= 1'b1;
         end else if (state == HOLD && out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

   nbit_CLA_full_adder #(
      .N(N)
   ) u_adder (
      .a   (a_reg),
      .b   (b_reg),
      .cin (1'b0),
      .sum (adder_sum)
   );

endmodule

// File: tb/tb_cla_operand_sequencer.sv
// Directed bench for cla_operand_sequencer with N=64, CHUNK_W=8.
// Inputs driven 1ns after the rising edge; outputs sampled at the same point.
// Scenarios: reset, basic add, backpressure, carry-out, gaps, mid-load reset, back-to-back.
module tb_cla_operand_sequencer;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [7:0]  in_data;
   logic        out_valid;
   logic        out_ready;
   logic [64:0] out_sum;

   int errors = 0;
   int checks = 0;
   int hs_count = 0;

   cla_operand_sequencer #(
      .N(64),
      .CHUNK_W(8)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_sum   (out_sum)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (in_valid && in_ready) hs_count++;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_chunk(input logic [7:0] d, input bit gap);
      int n = 0;
      in_valid = 1'b1;
      in_data  = d;
      while (!in_ready && n < 50) begin
         tick();
         n++;
      end
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL send_chunk_ready: in_ready=%b required 1", in_ready);
      end
      tick();
      in_valid = 1'b0;
      in_data  = 8'($urandom);
      if (gap) begin
         repeat (2) begin
            in_data = 8'($urandom);
            tick();
         end
      end
   endtask

   task automatic send_word(input logic [63:0] w, input bit gap);
      for (int i = 0; i < 8; i++) send_chunk(w[i*8 +: 8], gap);
   endtask

   task automatic wait_valid(output bit ok);
      int n = 0;
      while (!out_valid && n < 40) begin
         tick();
         n++;
      end
      ok = out_valid;
   endtask

   task automatic test_reset();
      #3;
      checks++;
      if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b required 0", in_ready); end
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b required 0", out_valid); end
      checks++;
      if (out_sum !== 65'h0) begin errors++; $display("FAIL reset_out_sum: got %h required 0", out_sum); end
      tick();
      rst = 1'b0;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_release_in_ready: got %b required 1", in_ready); end
      tick();
   endtask

   task automatic test_basic();
      out_ready = 1'b0;
      send_word(64'h00000F8010000700, 1'b0);
      send_word(64'h004002C0C200FC00, 1'b0);
      // One edge after the last beat: in the ADD cycle, result not yet visible.
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_add_cycle_valid: got %b required 0", out_valid); end
      checks++;
      if (in_ready !== 1'b0) begin errors++; $display("FAIL basic_add_cycle_ready: got %b required 0", in_ready); end
      tick();
      checks++;
      if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_valid: got %b required 1", out_valid); end
      checks++;
      if (out_sum !== 65'h00401240D2010300) begin errors++; $display("FAIL basic_sum: got %h required 00401240d2010300", out_sum); end
   endtask

   task automatic test_backpressure();
      for (int c = 0; c < 5; c++) begin
         tick();
         checks++;
         if (out_valid !== 1'b1) begin errors++; $display("FAIL stall_valid cycle %0d: got %b required 1", c, out_valid); end
         checks++;
         if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_ready cycle %0d: got %b required 0", c, in_ready); end
         checks++;
         if (out_sum !== 65'h00401240D2010300) begin errors++; $display("FAIL stall_sum cycle %0d: got %h required 00401240d2010300", c, out_sum); end
      end
      out_ready = 1'b1;
      tick();
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL release_valid: got %b required 0", out_valid); end
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL release_ready: got %b required 1", in_ready); end
      out_ready = 1'b0;
   endtask

   task automatic test_carry();
      out_ready = 1'b0;
      send_word(64'hFFFFFFFFFFFFFFFF, 1'b0);
      send_word(64'h0000000000000001, 1'b0);
      tick();
      checks++;
      if (out_valid !== 1'b1) begin errors++; $display("FAIL carry_valid: got %b required 1", out_valid); end
      checks++;
      if (out_sum !== 65'h1_0000000000000000) begin errors++; $display("FAIL carry_sum: got %h required 10000000000000000", out_sum); end
      checks++;
      if (out_sum[64] !== 1'b1) begin errors++; $display("FAIL carry_bit: got %b required 1", out_sum[64]); end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   task automatic test_gaps();
      bit ok;
      out_ready = 1'b0;
      hs_count  = 0;
      send_word(64'h00000F8010000700, 1'b1);
      send_word(64'h004002C0C200FC00, 1'b1);
      wait_valid(ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL gaps_timeout: out_valid=%b required 1", out_valid); end
      checks++;
      if (out_sum !== 65'h00401240D2010300) begin errors++; $display("FAIL gaps_sum: got %h required 00401240d2010300", out_sum); end
      checks++;
      if (hs_count !== 16) begin errors++; $display("FAIL gaps_beats: got %0d required 16", hs_count); end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   task automatic test_reset_mid();
      out_ready = 1'b0;
      send_chunk(8'hAA, 1'b0);
      send_chunk(8'hBB, 1'b0);
      send_chunk(8'hCC, 1'b0);
      #4;
      rst = 1'b1;
      #1;
      checks++;
      if (in_ready !== 1'b0) begin errors++; $display("FAIL midrst_in_ready: got %b required 0", in_ready); end
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_out_valid: got %b required 0", out_valid); end
      checks++;
      if (out_sum !== 65'h0) begin errors++; $display("FAIL midrst_out_sum: got %h required 0", out_sum); end
      #9;
      rst = 1'b0;
      tick();
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL midrst_resume_ready: got %b required 1", in_ready); end
      send_word(64'h5, 1'b0);
      send_word(64'h3, 1'b0);
      tick();
      checks++;
      if (out_valid !== 1'b1) begin errors++; $display("FAIL midrst_valid: got %b required 1", out_valid); end
      checks++;
      if (out_sum !== 65'h8) begin errors++; $display("FAIL midrst_sum: got %h required 8", out_sum); end
      out_ready = 1'b1;
      tick();
   endtask

   task automatic test_back_to_back();
      logic [63:0] words [4];
      logic [7:0]  chunks [32];
      logic [64:0] sums [2];
      int          rise [2];
      int          nres = 0;
      int          idx = 0;
      bit          pre;
      bit          prev_ov;
      words[0] = 64'h0123456789ABCDEF;
      words[1] = 64'hFEDCBA9876543210;
      words[2] = 64'h8000000000000000;
      words[3] = 64'h8000000000000001;
      for (int w = 0; w < 4; w++)
         for (int i = 0; i < 8; i++) chunks[w*8+i] = words[w][i*8 +: 8];
      sums[0] = '0; sums[1] = '0; rise[0] = 0; rise[1] = 0;
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_data   = chunks[0];
      prev_ov   = out_valid;
      for (int cyc = 1; cyc <= 60; cyc++) begin
         pre = in_valid && in_ready;
         tick();
         if (pre) idx++;
         if (idx < 32) in_data = chunks[idx];
         else          in_valid = 1'b0;
         if (out_valid && !prev_ov && nres < 2) begin
            rise[nres] = cyc;
            sums[nres] = out_sum;
            nres++;
         end
         prev_ov = out_valid;
      end
      in_valid = 1'b0;
      checks++;
      if (nres !== 2) begin errors++; $display("FAIL b2b_count: got %0d results required 2", nres); end
      checks++;
      if (sums[0] !== 65'h0_FFFFFFFFFFFFFFFF) begin errors++; $display("FAIL b2b_sum0: got %h required 0ffffffffffffffff", sums[0]); end
      checks++;
      if (sums[1] !== 65'h1_0000000000000001) begin errors++; $display("FAIL b2b_sum1: got %h required 10000000000000001", sums[1]); end
      checks++;
      if (rise[1] - rise[0] !== 18) begin errors++; $display("FAIL b2b_spacing: got %0d cycles required 18", rise[1] - rise[0]); end
   endtask

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_data   = 8'h00;
      out_ready = 1'b0;
      test_reset();
      test_basic();
      test_backpressure();
      test_carry();
      test_gaps();
      test_reset_mid();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
